cache_mem_arbiter: RTL and testbench

Two-port cache-line memory arbiter between the I-cache and D-cache memory-side masters and a single shared memory/AXI master port. Each cache request (strobe pulse) is latched into a pending slot, one request is granted at a time with round-robin priority, the transaction is issued to the shared port, and the returned line is forwarded with a one-cycle done pulse. The block sits between the cache modules and the external master IP, so only one memory port is exposed per core.

---
 rtl/cache_mem_arbiter_if.sv | 35 +++
 rtl/cache_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and shared-memory-side signal bundle for cache_mem_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned CACHE_LINE_SIZE = 256
);
    logic                       i_strobe;
    logic [ADDR_WIDTH-1:0]      i_addr;
    logic                       i_done;
    logic [CACHE_LINE_SIZE-1:0] i_datain;

    logic                       d_strobe;
    logic [ADDR_WIDTH-1:0]      d_addr;
    logic                       d_rw;
    logic [CACHE_LINE_SIZE-1:0] d_dataout;
    logic                       d_done;
    logic [CACHE_LINE_SIZE-1:0] d_datain;

    logic                       m_strobe;
    logic [ADDR_WIDTH-1:0]      m_addr;
    logic                       m_rw;
    logic [CACHE_LINE_SIZE-1:0] m_dataout;
    logic                       m_done;
    logic [CACHE_LINE_SIZE-1:0] m_datain;

    modport master (
        input  i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_datain,
        output i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dataout
    );

    modport slave (
        output i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_datain,
        input  i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dataout
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter funnelling I-cache and D-cache line requests onto one
// shared memory port; one transaction in flight, all outputs registered.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned CACHE_LINE_SIZE = 256
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.master bus
);
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned LW = CACHE_LINE_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_pend_i;
    logic            r_pend_d;
    logic [AW-1:0]   r_i_addr;
    logic [AW-1:0]   r_d_addr;
    logic            r_d_rw;
    logic [LW-1:0]   r_d_line;

    // Last granted side (1 = D); also identifies the side in flight.
    logic            r_last_d;
    logic            w_grant_d;

    logic            w_clr_i;
    logic            w_clr_d;
    logic            w_acc_i;
    logic            w_acc_d;
    logic            w_issue;
    logic            w_resp;

    logic            r_m_strobe;
    logic [AW-1:0]   r_m_addr;
    logic            r_m_rw;
    logic [LW-1:0]   r_m_dataout;
    logic            r_i_done;
    logic [LW-1:0]   r_i_datain;
    logic            r_d_done;
    logic [LW-1:0]   r_d_datain;

    // A strobe landing on its own side's RESP cycle re-arms the slot being freed.
    assign w_clr_i = (r_state == RESP) && !r_last_d;
    assign w_clr_d = (r_state == RESP) &&  r_last_d;
    assign w_acc_i = bus.i_strobe && (!r_pend_i || w_clr_i);
    assign w_acc_d = bus.d_strobe && (!r_pend_d || w_clr_d);
    assign w_issue = (r_state == IDLE) && (w_next == ISSUE);
    assign w_resp  = (r_state == WAIT) && bus.m_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant_d = r_last_d;
        case (r_state)
            IDLE: begin
                if (r_pend_i || r_pend_d) begin
                    w_next    = ISSUE;
                    w_grant_d = r_pend_d && (!r_pend_i || !r_last_d);
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT:    if (bus.m_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pending request slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_i <= 1'b0;
            r_pend_d <= 1'b0;
            r_i_addr <= '0;
            r_d_addr <= '0;
            r_d_rw   <= 1'b0;
            r_d_line <= '0;
        end else begin
            if (w_acc_i) begin
                r_pend_i <= 1'b1;
                r_i_addr <= bus.i_addr;
            end else if (w_clr_i) begin
                r_pend_i <= 1'b0;
            end
            if (w_acc_d) begin
                r_pend_d <= 1'b1;
                r_d_addr <= bus.d_addr;
                r_d_rw   <= bus.d_rw;
                r_d_line <= bus.d_dataout;
            end else if (w_clr_d) begin
                r_pend_d <= 1'b0;
            end
        end
    end

    // Shared-port drive and response forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d    <= 1'b0;
            r_m_strobe  <= 1'b0;
            r_m_addr    <= '0;
            r_m_rw      <= 1'b0;
            r_m_dataout <= '0;
            r_i_done    <= 1'b0;
            r_i_datain  <= '0;
            r_d_done    <= 1'b0;
            r_d_datain  <= '0;
        end else begin
            r_m_strobe <= w_issue;
            if (w_issue) begin
                r_last_d    <= w_grant_d;
                r_m_addr    <= w_grant_d ? r_d_addr : r_i_addr;
                r_m_rw      <= w_grant_d && r_d_rw;
                r_m_dataout <= w_grant_d ? r_d_line : '0;
            end
            r_i_done <= w_resp && !r_last_d;
            r_d_done <= w_resp &&  r_last_d;
            if (w_resp && !r_last_d) begin
                r_i_datain <= bus.m_datain;
            end
            if (w_resp && r_last_d && !r_m_rw) begin
                r_d_datain <= bus.m_datain;
            end
        end
    end

    assign bus.m_strobe  = r_m_strobe;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_rw      = r_m_rw;
    assign bus.m_dataout = r_m_dataout;
    assign bus.i_done    = r_i_done;
    assign bus.i_datain  = r_i_datain;
    assign bus.d_done    = r_d_done;
    assign bus.d_datain  = r_d_datain;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a latency-programmable memory responder.
module tb_cache_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic clk;
    logic rst;

    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_idone = 0;
    int n_ddone = 0;

    bit            resp_en  = 1'b1;
    int            resp_lat = 1;
    int            cnt      = 0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] glog[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 32'h8000_0100) return {32{8'hA5}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory responder and done-pulse counters, sampled 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.i_done) n_idone++;
        if (bus.d_done) n_ddone++;
        if (resp_en) begin
            bus.m_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.m_done   = 1'b1;
                    bus.m_datain = line_for(pend_addr);
                end
            end
            if (bus.m_strobe) begin
                cnt       = resp_lat;
                pend_addr = bus.m_addr;
                glog.push_back(bus.m_addr);
            end
        end
    end

    initial begin
        int            base_i;
        int            base_d;
        int            ni;
        int            nd;
        bit            seen;
        logic [LW-1:0] wline;

        rst           = 1'b1;
        bus.i_strobe  = 1'b0;
        bus.i_addr    = '0;
        bus.d_strobe  = 1'b0;
        bus.d_addr    = '0;
        bus.d_rw      = 1'b0;
        bus.d_dataout = '0;
        bus.m_done    = 1'b0;
        bus.m_datain  = '0;
        repeat (2) tick();

        check("rst_m_strobe", LW'(bus.m_strobe), '0);
        check("rst_m_addr",   LW'(bus.m_addr),   '0);
        check("rst_i_done",   LW'(bus.i_done),   '0);
        check("rst_d_done",   LW'(bus.d_done),   '0);
        check("rst_i_datain", bus.i_datain,      '0);
        check("rst_state",    LW'(dut.r_state),  '0);
        rst = 1'b0;
        tick();

        // Single I read, m_done one cycle after m_strobe.
        resp_lat     = 1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h8000_0100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.i_strobe = 1'b0;
            check($sformatf("t1_m_strobe_c%0d", c), LW'(bus.m_strobe), LW'(c == 2));
            check($sformatf("t1_i_done_c%0d", c),   LW'(bus.i_done),   LW'(c == 4));
            check($sformatf("t1_d_done_c%0d", c),   LW'(bus.d_done),   '0);
            if (c == 2) begin
                check("t1_m_addr", LW'(bus.m_addr), LW'(32'h8000_0100));
                check("t1_m_rw",   LW'(bus.m_rw),   '0);
            end
            if (c == 4) check("t1_i_datain", bus.i_datain, {32{8'hA5}});
        end

        // D write-back, m_done four cycles after m_strobe.
        base_d        = n_ddone;
        resp_lat      = 4;
        wline         = {8{32'h1234_5678}};
        bus.d_strobe  = 1'b1;
        bus.d_rw      = 1'b1;
        bus.d_addr    = 32'h8000_2000;
        bus.d_dataout = wline;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.d_strobe = 1'b0;
            check($sformatf("t2_m_strobe_c%0d", c), LW'(bus.m_strobe), LW'(c == 2));
            check($sformatf("t2_d_done_c%0d", c),   LW'(bus.d_done),   LW'(c == 7));
            if (c >= 2 && c <= 6) begin
                check($sformatf("t2_m_rw_c%0d", c),      LW'(bus.m_rw),   LW'(1));
                check($sformatf("t2_m_dataout_c%0d", c), bus.m_dataout,   wline);
                check($sformatf("t2_m_addr_c%0d", c),    LW'(bus.m_addr), LW'(32'h8000_2000));
            end
        end
        check("t2_d_datain_kept", bus.d_datain, '0);
        check("t2_d_done_count",  LW'(n_ddone - base_d), LW'(1));
        bus.d_rw = 1'b0;

        // Simultaneous strobes straight after reset: D first, I second.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        resp_lat     = 1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h0000_1100;
        bus.d_strobe = 1'b1;
        bus.d_addr   = 32'h0000_2200;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.i_strobe = 1'b0;
            bus.d_strobe = 1'b0;
            check($sformatf("t3_m_strobe_c%0d", c), LW'(bus.m_strobe), LW'(c == 2 || c == 6));
            check($sformatf("t3_d_done_c%0d", c),   LW'(bus.d_done),   LW'(c == 4));
            check($sformatf("t3_i_done_c%0d", c),   LW'(bus.i_done),   LW'(c == 8));
            if (c == 2) check("t3_first_addr",  LW'(bus.m_addr), LW'(32'h0000_2200));
            if (c == 6) check("t3_second_addr", LW'(bus.m_addr), LW'(32'h0000_1100));
            if (c == 4) check("t3_d_datain", bus.d_datain, line_for(32'h0000_2200));
            if (c == 8) check("t3_i_datain", bus.i_datain, line_for(32'h0000_1100));
        end

        // Alternation under load: both sides re-strobe on their own done cycle.
        glog.delete();
        base_i       = n_idone;
        base_d       = n_ddone;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h0000_1000;
        bus.d_strobe = 1'b1;
        bus.d_addr   = 32'h0000_2000;
        ni = 1;
        nd = 1;
        for (int c = 0; c < 150 && glog.size() < 8; c++) begin
            tick();
            bus.i_strobe = 1'b0;
            bus.d_strobe = 1'b0;
            if (bus.i_done && ni < 4) begin
                bus.i_strobe = 1'b1;
                bus.i_addr   = AW'(32'h0000_1000 + ni * 64);
                ni++;
            end
            if (bus.d_done && nd < 4) begin
                bus.d_strobe = 1'b1;
                bus.d_addr   = AW'(32'h0000_2000 + nd * 64);
                nd++;
            end
        end
        bus.i_strobe = 1'b0;
        bus.d_strobe = 1'b0;
        check("t4_grant_count", LW'(glog.size()), LW'(8));
        for (int k = 0; k < glog.size(); k++) begin
            check($sformatf("t4_grant%0d_is_d", k), LW'(glog[k][13]), LW'(k % 2 == 0));
        end
        repeat (10) tick();
        check("t4_i_done_count", LW'(n_idone - base_i), LW'(4));
        check("t4_d_done_count", LW'(n_ddone - base_d), LW'(4));

        // Reset during WAIT, then a stray m_done.
        resp_en      = 1'b0;
        cnt          = 0;
        bus.m_done   = 1'b0;
        base_i       = n_idone;
        base_d       = n_ddone;
        bus.d_strobe = 1'b1;
        bus.d_rw     = 1'b0;
        bus.d_addr   = 32'h0000_3000;
        tick();
        bus.d_strobe = 1'b0;
        tick();
        check("t5_issue", LW'(bus.m_strobe), LW'(1));
        tick();
        check("t5_in_wait", LW'(dut.r_state), LW'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_state_after_rst", LW'(dut.r_state), '0);
        tick();
        bus.m_done   = 1'b1;
        bus.m_datain = {LW{1'b1}};
        tick();
        bus.m_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t5_m_strobe_%0d", c), LW'(bus.m_strobe), '0);
            check($sformatf("t5_state_%0d", c),    LW'(dut.r_state),  '0);
            tick();
        end
        check("t5_no_i_done", LW'(n_idone - base_i), '0);
        check("t5_no_d_done", LW'(n_ddone - base_d), '0);
        check("t5_d_datain",  bus.d_datain, '0);

        cnt          = 0;
        resp_en      = 1'b1;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h0000_4000;
        tick();
        bus.i_strobe = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = bus.i_done;
        end
        check("t5_fresh_done",   LW'(seen),    LW'(1));
        check("t5_fresh_datain", bus.i_datain, line_for(32'h0000_4000));

        // Duplicate I strobe while pend_i is set is dropped.
        repeat (3) tick();
        base_i       = n_idone;
        bus.i_strobe = 1'b1;
        bus.i_addr   = 32'h0000_5000;
        tick();
        bus.i_addr   = 32'h0000_6000;
        tick();
        bus.i_strobe = 1'b0;
        check("t6_m_strobe", LW'(bus.m_strobe), LW'(1));
        check("t6_m_addr",   LW'(bus.m_addr),   LW'(32'h0000_5000));
        repeat (15) tick();
        check("t6_i_done_count", LW'(n_idone - base_i), LW'(1));
        check("t6_i_datain",     bus.i_datain, line_for(32'h0000_5000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
